// File: rtl/fir_filter_serial.sv
// fir_filter_serial: time-multiplexed signed FIR filter with a single shared multiplier.
// Accepts one sample per TAPS+2 cycles over a valid/ready handshake and emits a scaled result
// as a one-cycle out_valid pulse. Coefficients can be rewritten at runtime whenever the MAC
// loop is not running.
// Build option: define FIR_SAT_EN to saturate the scaled output and expose sat_flag;
// otherwise the scaled output wraps modulo 2^DATA_W.
module fir_filter_serial #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned COEF_W    = 18,
   parameter int unsigned TAPS      = 32,
   parameter int unsigned OUT_SHIFT = 17
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      coef_we,
   input  logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic [COEF_W-1:0]         coef_data,
   output logic                      coef_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic                      busy
`ifdef FIR_SAT_EN
   ,
   output logic                      sat_flag
`endif
);

   localparam int unsigned IW     = $clog2(TAPS);
   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam int unsigned ACC_W  = DATA_W + COEF_W + IW;

   localparam logic [IW:0]   TAPS_LIM = (IW + 1)'(TAPS);
   localparam logic [IW-1:0] IDX_LAST = IW'(TAPS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StMac,
      StOut
   } state_t;

   state_t                          r_state;
   logic [IW-1:0]                   r_idx;
   logic signed [ACC_W-1:0]         r_acc;
   logic [TAPS-1:0][DATA_W-1:0]     r_dly;
   logic [TAPS-1:0][COEF_W-1:0]     r_coef;
   logic                            r_in_ready;
   logic                            r_coef_ready;
   logic                            r_busy;
   logic                            r_out_valid;
   logic [DATA_W-1:0]               r_out_data;

   logic                            w_accept;
   logic                            w_coef_wr;
   logic signed [COEF_W-1:0]        w_cur_coef;
   logic signed [DATA_W-1:0]        w_cur_dly;
   logic signed [PROD_W-1:0]        w_prod;
   logic signed [ACC_W-1:0]         w_prod_ext;
   logic [DATA_W-1:0]               w_out;

   assign w_accept  = in_valid & r_in_ready;
   // Writes are dropped while the MAC loop is running and for out-of-range tap indices.
   assign w_coef_wr = coef_we & r_coef_ready & ({1'b0, coef_addr} < TAPS_LIM);

   // One tap product per cycle; the operands are widened first so the product is exact.
   assign w_cur_coef = $signed(r_coef[r_idx]);
   assign w_cur_dly  = $signed(r_dly[r_idx]);
   assign w_prod     = PROD_W'(w_cur_coef) * PROD_W'(w_cur_dly);
   assign w_prod_ext = ACC_W'(w_prod);

`ifdef FIR_SAT_EN
   logic signed [ACC_W-1:0]         w_shifted;
   logic [ACC_W-DATA_W:0]           w_hi;
   logic                            w_ovf;
   logic [DATA_W-1:0]               w_sat_val;
   logic                            r_sat_flag;

   assign w_shifted = r_acc >>> OUT_SHIFT;
   // The value fits in DATA_W bits only if everything above the output MSB is pure sign extension.
   assign w_hi      = w_shifted[ACC_W-1:DATA_W-1];
   assign w_ovf     = ~((&w_hi) | (~|w_hi));
   assign w_sat_val = w_shifted[ACC_W-1] ? {1'b1, {(DATA_W - 1){1'b0}}}
                                         : {1'b0, {(DATA_W - 1){1'b1}}};
   assign w_out     = w_ovf ? w_sat_val : w_shifted[DATA_W-1:0];
   assign sat_flag  = r_sat_flag;
`else
   // Keep the low DATA_W bits of the shifted accumulator (wraps modulo 2^DATA_W).
   assign w_out = DATA_W'(r_acc >>> OUT_SHIFT);
`endif

   // Control FSM: handshake flags, tap sequencing, accumulation and the output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= StIdle;
         r_idx        <= '0;
         r_acc        <= '0;
         r_in_ready   <= 1'b0;
         r_coef_ready <= 1'b1;
         r_busy       <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
`ifdef FIR_SAT_EN
         r_sat_flag   <= 1'b0;
`endif
      end else begin
         r_out_valid <= 1'b0;
`ifdef FIR_SAT_EN
         r_sat_flag  <= 1'b0;
`endif
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_acc        <= '0;
                  r_idx        <= '0;
                  r_in_ready   <= 1'b0;
                  r_coef_ready <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= StMac;
               end else begin
                  // Also raises in_ready on the first edge after reset release.
                  r_in_ready <= 1'b1;
               end
            end
            StMac: begin
               r_acc <= r_acc + w_prod_ext;
               if (r_idx == IDX_LAST) begin
                  r_busy       <= 1'b0;
                  r_coef_ready <= 1'b1;
                  r_state      <= StOut;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            StOut: begin
               r_out_data  <= w_out;
               r_out_valid <= 1'b1;
`ifdef FIR_SAT_EN
               r_sat_flag  <= w_ovf;
`endif
               r_in_ready  <= 1'b1;
               r_state     <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   // Delay line: shifts on every accepted sample, newest sample at tap 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dly <= '0;
      end else if (w_accept) begin
         r_dly <= {r_dly[TAPS-2:0], in_data};
      end
   end

   // Coefficient bank: a write coincident with an accept lands before that sample's first product.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_coef <= '0;
      end else if (w_coef_wr) begin
         r_coef[coef_addr] <= coef_data;
      end
   end

   assign in_ready   = r_in_ready;
   assign coef_ready = r_coef_ready;
   assign busy       = r_busy;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;

endmodule

// File: tb/tb_fir_filter_serial.sv
// Scoreboard bench for fir_filter_serial (default parameters, OUT_SHIFT=17).
// Stimulus pushes expected outputs; an independent monitor pops them on each out_valid pulse.
module tb_fir_filter_serial;

   localparam int DATA_W    = 16;
   localparam int COEF_W    = 18;
   localparam int TAPS      = 32;
   localparam int OUT_SHIFT = 17;
   localparam int LAT       = TAPS + 1;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [15:0]       in_data = '0;
   logic              coef_we = 1'b0;
   logic [4:0]        coef_addr = '0;
   logic [17:0]       coef_data = '0;
   logic              in_ready;
   logic              coef_ready;
   logic              out_valid;
   logic [15:0]       out_data;
   logic              busy;
`ifdef FIR_SAT_EN
   logic              sat_flag;
`endif

   fir_filter_serial #(
      .DATA_W    (DATA_W),
      .COEF_W    (COEF_W),
      .TAPS      (TAPS),
      .OUT_SHIFT (OUT_SHIFT)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .coef_ready (coef_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
`ifdef FIR_SAT_EN
      .sat_flag   (sat_flag),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] data;
      logic        flag;
      int          acc_cyc;
      int          tag;
   } exp_t;

   exp_t sbq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every out_valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            check("out_valid_without_sample", 32'(out_valid), 32'd0);
         end else begin
            e = sbq.pop_front();
            check($sformatf("out_data_t%0d", e.tag), 32'(out_data), 32'(e.data));
            check($sformatf("latency_t%0d", e.tag), 32'(cyc - e.acc_cyc), 32'(LAT));
`ifdef FIR_SAT_EN
            check($sformatf("sat_flag_t%0d", e.tag), 32'(sat_flag), 32'(e.flag));
`endif
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [15:0] d, input logic [15:0] ed, input logic ef, input int tag,
                       input logic we = 1'b0, input logic [4:0] wa = '0,
                       input logic [17:0] wd = '0);
      int n = 0;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         check($sformatf("in_ready_wait_t%0d", tag), 32'(in_ready), 32'd1);
         return;
      end
      in_valid  = 1'b1;
      in_data   = d;
      coef_we   = we;
      coef_addr = wa;
      coef_data = wd;
      sbq.push_back('{ed, ef, cyc + 1, tag});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      @(negedge clk);
   endtask

   task automatic wr_coef(input logic [4:0] a, input logic [17:0] d);
      check("coef_ready_idle", 32'(coef_ready), 32'd1);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((sbq.size() != 0 || in_ready !== 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", 32'(sbq.size()), 32'd0);
   endtask

   // Expected result of k taps each contributing 32767 * 131071, after the >>>17 scaling.
   function automatic void ovf_exp(input int k, output logic [15:0] d, output logic f);
      longint acc;
      longint sh;
      acc = longint'(k) * 32767 * 131071;
      sh  = acc >>> 17;
      f   = 1'b0;
`ifdef FIR_SAT_EN
      if (sh > 32767) begin
         d = 16'h7FFF;
         f = 1'b1;
      end else begin
         d = sh[15:0];
      end
`else
      d = sh[15:0];
`endif
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ed;
      logic        ef;
      int          accepts;
      int          last;
      int          n;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_coef_ready", 32'(coef_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_release", 32'(in_ready), 32'd1);

      // Impulse: coef[k]=(k+1)*8, input 16384 -> each output = coef/8 = k+1
      for (int k = 0; k < TAPS; k++) wr_coef(5'(k), 18'((k + 1) * 8));
      send(16'd16384, 16'd1, 1'b0, 0);
      check("mac_busy", 32'(busy), 32'd1);
      check("mac_in_ready", 32'(in_ready), 32'd0);
      check("mac_coef_ready", 32'(coef_ready), 32'd0);
      for (int k = 1; k < TAPS; k++) send(16'd0, 16'(k + 1), 1'b0, k);
      send(16'd0, 16'd0, 1'b0, 32);
      drain();

      // Write to tap 3 during MAC is dropped; a write coincident with an accept is used.
      send(16'd16384, 16'd1, 1'b0, 100);
      repeat (2) @(negedge clk);
      check("coef_ready_in_mac", 32'(coef_ready), 32'd0);
      coef_we   = 1'b1;
      coef_addr = 5'd3;
      coef_data = 18'd800;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      @(negedge clk);
      send(16'd0, 16'd2, 1'b0, 101);
      send(16'd0, 16'd3, 1'b0, 102);
      send(16'd0, 16'd4, 1'b0, 103);
      send(16'd16384, 16'd6, 1'b0, 104);
      send(16'd0, 16'd8, 1'b0, 105);
      send(16'd0, 16'd10, 1'b0, 106);
      send(16'd0, 16'd108, 1'b0, 107, 1'b1, 5'd3, 18'd800);
      drain();

      // Negative arithmetic: only coef[0]=-131072 is non-zero.
      for (int k = 0; k < TAPS; k++) wr_coef(5'(k), (k == 0) ? 18'h20000 : 18'h0);
`ifdef FIR_SAT_EN
      send(16'h8000, 16'h7FFF, 1'b1, 200);
`else
      send(16'h8000, 16'h8000, 1'b0, 200);
`endif
      send(16'd16384, 16'hC000, 1'b0, 201);
      send(16'hFFFF, 16'h0001, 1'b0, 202);
      send(16'd3, 16'hFFFD, 1'b0, 203);
      // Flush the delay line with zeros so the next test starts from a known state.
      for (int k = 0; k < TAPS; k++) send(16'd0, 16'd0, 1'b0, 300 + k);
      drain();

      // Overflow with in_valid held high: accepts must be spaced TAPS+2 cycles apart.
      for (int k = 0; k < TAPS; k++) wr_coef(5'(k), 18'h1FFFF);
      in_valid = 1'b1;
      in_data  = 16'h7FFF;
      accepts  = 0;
      last     = -1;
      n        = 0;
      while (accepts < 36 && n < 2000) begin
         if (in_ready === 1'b1) begin
            if (last >= 0) check("accept_gap", 32'(cyc - last), 32'(TAPS + 2));
            last = cyc;
            ovf_exp((accepts + 1 > TAPS) ? TAPS : accepts + 1, ed, ef);
            sbq.push_back('{ed, ef, cyc + 1, 400 + accepts});
            accepts++;
         end
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      check("stream_accepts", 32'(accepts), 32'd36);
      drain();

      // Reset in the middle of a MAC: no output, everything back to reset values.
      in_valid = 1'b1;
      in_data  = 16'h7FFF;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_coef_ready", 32'(coef_ready), 32'd1);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      check("post_rst_out_data", 32'(out_data), 32'd0);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      send(16'h7FFF, 16'd0, 1'b0, 500);
      send(16'h7FFF, 16'd0, 1'b0, 501);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_filter_serial.md
Name: fir_filter_serial

Overview:
- Parametrised, time-multiplexed signed FIR filter; next generation of the team's fixed 16-bit tapped-delay FIR used inside the adaptive-filter loop.
- One multiplier shared across all taps: one sample in per TAPS+2 cycles.
- valid/ready sample handshake, runtime coefficient write port, scaled output with selectable overflow handling.
- Sits between the ADC sample stream and the adaptive coefficient-update logic.

Parameters:
DATA_W, 16, sample input/output width, signed two's complement
COEF_W, 18, coefficient width, signed two's complement
TAPS, 32, number of taps / delay-line depth (2..256)
OUT_SHIFT, 17, arithmetic right shift applied to accumulator before output

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  sample offered
in_ready  out  1  block can accept a sample
in_data  in  DATA_W  signed input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  tap index
coef_data  in  COEF_W  signed coefficient value
coef_ready  out  1  coefficient write will be accepted this cycle
out_valid  out  1  one-cycle pulse, out_data valid
out_data  out  DATA_W  signed filtered sample
busy  out  1  MAC in progress

Behaviour:
- Reset (async assert, sync release): in_ready=0 during reset, 1 in the first cycle after release; coef_ready=1; out_valid=0; out_data=0; busy=0; delay line, coefficients and accumulator cleared to 0.
- ACC_W = DATA_W+COEF_W+clog2(TAPS); all products and sums are sign-extended to ACC_W, so no internal overflow occurs.
- FSM states: IDLE, MAC, OUT.
- IDLE: in_ready=1.
  - in_valid&in_ready: shift delay line (d[k]<=d[k-1], d[0]<=in_data), clear accumulator, tap index<=0, go to MAC.
- MAC: one product per cycle, acc += coef[i]*d[i], i = 0..TAPS-1 (TAPS cycles).
  - Sum includes the sample just accepted.
  - busy=1; in_ready=0.
  - After i=TAPS-1, go to OUT.
- OUT: out_data <= scale(acc); out_valid=1 for exactly one cycle; go to IDLE.
- Latency: accept edge to out_valid high = TAPS+1 clocks. Maximum throughput is one sample per TAPS+2 cycles.
- Back-to-back: a sample may be accepted in the IDLE cycle directly after OUT.
- No output backpressure: downstream must sample out_data on the out_valid pulse. out_data holds its value until the next OUT.
- Coefficient port:
  - coef_ready=1 in IDLE and OUT, 0 in MAC.
  - coef_we with coef_ready=1 writes coef[coef_addr] on that edge.
  - coef_we with coef_ready=0 is ignored (dropped, no queuing).
  - coef_addr >= TAPS is ignored.
  - A write in the same cycle as a sample accept takes effect for that sample's MAC.
- scale(acc) = acc >>> OUT_SHIFT (arithmetic), then reduced to DATA_W per Optional Feature.
- Reset mid-MAC: the partial result is discarded and no out_valid is issued; all state returns to reset values.
- in_valid while in_ready=0: the sample is not consumed; the upstream source must hold it.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined: the shifted value saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; an extra output sat_flag (1 bit) pulses with out_valid when clipping occurred; sat_flag reset value 0.
- Undefined: the shifted value is truncated to its low DATA_W bits (wraps modulo 2^DATA_W); no sat_flag port.

Test Plan:
- Impulse (defaults): coef[k]=k+1 for k=0..31, OUT_SHIFT=0 variant; feed 1 then 31 zeros -> outputs 1,2,...,32 in order, each out_valid exactly 33 cycles after its accept.
- Handshake: hold in_valid=1 continuously -> in_ready high only one cycle in every 34, one output per accepted sample, no sample lost or duplicated.
- Coefficient write blocking: coef_we to addr 3 during MAC -> coef_ready=0, coefficient unchanged. Same write in IDLE coincident with an accept -> new value used in that sample's sum.
- Overflow: all coef=2^17-1, input 32767 held, OUT_SHIFT=17.
  - FIR_SAT_EN defined -> out_data=32767, sat_flag=1.
  - FIR_SAT_EN undefined -> out_data equals the low 16 bits of the shifted accumulator.
- Negative arithmetic: coef[0]=-1, all others 0, input -32768, OUT_SHIFT=0 -> out_data=32767 with sat_flag=1 under FIR_SAT_EN, -32768 (wrap) without.
- Reset mid-MAC: assert reset_n=0 at MAC cycle 10 -> out_valid never pulses, out_data=0, coefficients 0; after release, impulse input -> out_data=0.
